// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of an asynchronous pulse and
// publishes each period through a registered valid/ready output.
module pulse_period_meter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_PERIOD  = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   pulse_edge;
  logic                   publish;
  logic                   stall_hit;

  // Edge is registered so the FSM sees it one clock after the prev flop
  // would allow; this fixes out_valid at SYNC_STAGES+1 clocks after sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pulse_edge  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      pulse_edge  <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    publish   = 1'b0;
    stall_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_edge) begin
          cnt_d   = ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (pulse_edge) begin
          publish = 1'b1;
          cnt_d   = ONE;
        end else if (cnt_q == MAX_CNT) begin
          stall_hit = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      stalled   <= 1'b1;
    end else begin
      if (publish) begin
        period    <= cnt_q;
        out_valid <= 1'b1;
        stalled   <= 1'b0;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (stall_hit) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (WIDTH=8, MAX_PERIOD=255): vector
// table for steady periods plus hand sequences for latency, stall, overrun.
module tb_pulse_period_meter;

  logic       clk;
  logic       reset;
  logic       pulse_in;
  logic [7:0] period;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       stalled;

  int checks = 0;
  int errors = 0;

  pulse_period_meter #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .MAX_PERIOD(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pulse_in(pulse_in),
    .period(period),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
    .stalled(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int exp_valid;
    int exp_period;
    int exp_overrun;
    int exp_stalled;
  } vec_t;

  vec_t vecs[6];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pulse_in  = 1'b0;
    out_ready = 1'b0;
    step(3);
    reset = 1'b0;
  endtask

  // Raise pulse_in for one cycle and advance to the clock where a sample lands.
  task automatic fire();
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
    step(3);
  endtask

  task automatic check_outs(input string tag, input int v, input int p, input int o, input int s);
    check({tag, "_valid"}, int'(out_valid), v);
    check({tag, "_period"}, int'(period), p);
    check({tag, "_overrun"}, int'(overrun), o);
    check({tag, "_stalled"}, int'(stalled), s);
  endtask

  initial begin
    int nvalid;

    vecs[0] = '{gap: 0,   exp_valid: 0, exp_period: 0,   exp_overrun: 0, exp_stalled: 1};
    vecs[1] = '{gap: 100, exp_valid: 1, exp_period: 100, exp_overrun: 0, exp_stalled: 0};
    vecs[2] = '{gap: 100, exp_valid: 1, exp_period: 100, exp_overrun: 0, exp_stalled: 0};
    vecs[3] = '{gap: 255, exp_valid: 1, exp_period: 255, exp_overrun: 0, exp_stalled: 0};
    vecs[4] = '{gap: 7,   exp_valid: 1, exp_period: 7,   exp_overrun: 0, exp_stalled: 0};
    vecs[5] = '{gap: 100, exp_valid: 1, exp_period: 100, exp_overrun: 0, exp_stalled: 0};

    do_reset();
    check_outs("reset", 0, 0, 0, 1);

    // Steady stream with consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(vecs[i].gap - 5);
      fire();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_period,
                 vecs[i].exp_overrun, vecs[i].exp_stalled);
      step(1);
      check($sformatf("vec%0d_valid_drop", i), int'(out_valid), 0);
    end

    // Latency: out_valid rises SYNC_STAGES+1 clocks after pulse_in is sampled.
    step(95);
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
    step(2);
    check("lat_early", int'(out_valid), 0);
    step(1);
    check("lat_valid", int'(out_valid), 1);
    check("lat_period", int'(period), 100);
    step(1);

    // Minimum period of 2: alternating input.
    for (int i = 0; i < 5; i++) begin
      pulse_in = 1'b1; step(1);
      pulse_in = 1'b0; step(1);
    end
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      pulse_in = 1'b1; step(1);
      check("p2_period", int'(period), 2);
      nvalid += int'(out_valid);
      pulse_in = 1'b0; step(1);
      check("p2_period", int'(period), 2);
      nvalid += int'(out_valid);
    end
    check("p2_sample_count", nvalid, 10);

    // Stall: silence after an edge, stalled rises exactly 255 cycles later.
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
    step(257);
    check("stall_before", int'(stalled), 0);
    step(1);
    check("stall_at", int'(stalled), 1);
    step(20);
    fire();
    check_outs("stall_restart", 0, 2, 0, 1);
    step(56);
    fire();
    check_outs("stall_recover", 1, 60, 0, 0);

    // Overrun: consumer stalls across two samples of period 50.
    step(1);
    out_ready = 1'b0;
    step(45);
    fire();
    check_outs("ovr_first", 1, 50, 0, 0);
    step(46);
    fire();
    check_outs("ovr_second", 1, 50, 1, 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("ovr_drain_valid", int'(out_valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    step(10);
    check("ovr_sticky_later", int'(overrun), 1);

    // Publish coinciding with a transfer: no overrun.
    do_reset();
    check_outs("reset2", 0, 0, 0, 1);
    fire();
    step(36);
    fire();
    check_outs("sim_pending", 1, 40, 0, 0);
    step(66);
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_outs("sim_publish", 1, 70, 0, 0);

    // Reset 30 cycles into a 100-cycle period.
    out_ready = 1'b1;
    step(5);
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
    step(29);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check_outs("midreset", 0, 0, 0, 1);
    fire();
    check_outs("midreset_first", 0, 0, 0, 1);
    step(96);
    fire();
    check_outs("midreset_second", 1, 100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
